// File: rtl/xsim_source_arbiter.sv
// xsim_source_arbiter: round-robin arbiter that forwards whole length-prefixed
// messages from NUM_SRC requesters onto a single beat stream. The first beat of
// each message is a header whose low LEN_W bits give the total beat count
// (0 is treated as 1). Arbitration happens only between messages.
module xsim_source_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int LEN_W   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [32*NUM_SRC-1:0]  src_beat,
    input  logic [32*NUM_SRC-1:0]  src_portal,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic                   out_ready,
    output logic                   en_beat,
    output logic [31:0]            portal,
    output logic [31:0]            beat,
    output logic [31:0]            msg_count,
    output logic                   busy
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   rr_ptr;
    logic [LEN_W-1:0]   remaining;
    logic               hdr_seen;   // header of the current message already accepted

    logic [SEL_W-1:0]   pick;
    logic [SEL_W-1:0]   next_rr;
    logic [31:0]        sel_beat;
    logic [31:0]        sel_portal;
    logic [LEN_W-1:0]   hdr_len;
    logic               accept;
    logic               last_beat;

    // Data path of the granted requester.
    assign sel_beat   = src_beat[32*int'(grant) +: 32];
    assign sel_portal = src_portal[32*int'(grant) +: 32];
    assign hdr_len    = sel_beat[LEN_W-1:0];
    assign accept     = (state == BURST) && src_valid[grant] && out_ready;
    assign busy       = (state == BURST);
    assign next_rr    = (int'(grant) == NUM_SRC - 1) ? '0 : grant + 1'b1;

    // A message ends on a header of length 0/1, or on the data beat that
    // brings the remaining count to zero.
    assign last_beat  = hdr_seen ? (remaining == LEN_W'(1)) : (hdr_len <= LEN_W'(1));

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no latch is inferred.
        pick = rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (src_valid[SEL_W'((int'(rr_ptr) + k) % NUM_SRC)]) begin
                pick = SEL_W'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    // Only the granted requester sees out_ready, and nobody is ready in IDLE or reset.
    always_comb begin
        src_ready = '0;
        if (!RST && state == BURST) begin
            src_ready[grant] = out_ready;
        end
    end

    // Message FSM: grant in IDLE, forward beats in BURST, registered outputs.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            hdr_seen  <= 1'b0;
            en_beat   <= 1'b0;
            beat      <= '0;
            portal    <= '0;
            msg_count <= '0;
        end else begin
            en_beat <= 1'b0;
            case (state)
                IDLE: begin
                    if (|src_valid) begin
                        grant    <= pick;
                        hdr_seen <= 1'b0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        en_beat <= 1'b1;
                        beat    <= sel_beat;
                        if (!hdr_seen) begin
                            portal   <= sel_portal;
                            hdr_seen <= 1'b1;
                        end
                        if (last_beat) begin
                            state     <= IDLE;
                            remaining <= '0;
                            rr_ptr    <= next_rr;
                            msg_count <= msg_count + 32'd1;
                        end else if (hdr_seen) begin
                            remaining <= remaining - LEN_W'(1);
                        end else begin
                            remaining <= hdr_len - LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xsim_source_arbiter.sv
// Self-checking bench for xsim_source_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a message-level reference model.
module tb_xsim_source_arbiter;

    localparam int N = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N-1:0]      src_valid;
    logic [32*N-1:0]   src_beat;
    logic [32*N-1:0]   src_portal;
    logic [N-1:0]      src_ready;
    logic              out_ready;
    logic              en_beat;
    logic [31:0]       portal;
    logic [31:0]       beat;
    logic [31:0]       msg_count;
    logic              busy;

    xsim_source_arbiter #(.NUM_SRC(N), .LEN_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .src_valid  (src_valid),
        .src_beat   (src_beat),
        .src_portal (src_portal),
        .src_ready  (src_ready),
        .out_ready  (out_ready),
        .en_beat    (en_beat),
        .portal     (portal),
        .beat       (beat),
        .msg_count  (msg_count),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Per-source pending beats, portal numbers and random gaps.
    logic [31:0] src_q [N][$];
    logic [31:0] portal_in [N];
    logic [N-1:0] gap;

    // Reference model: message owner (-1 = between messages) and beats still owed.
    int          m_owner;
    int          m_left;     // 0 while the header is still to come
    int          m_rr;
    logic [31:0] m_count;
    logic        m_en;
    logic [31:0] m_beat;
    logic [31:0] m_portal;

    typedef struct {
        logic [31:0] b;
        logic [31:0] p;
        int          cyc;
        logic        acc_or;
    } ev_t;
    ev_t log_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic last_or;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_rr = 0; m_count = '0;
        m_en = 1'b0; m_beat = '0; m_portal = '0;
    endtask

    // Message-level behaviour for one clock edge, from the bench's own inputs.
    task automatic model_update();
        logic [31:0] bt;
        int n;
        if (RST) begin
            model_reset();
        end else if (m_owner < 0) begin
            m_en = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && src_valid[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    m_left  = 0;
                end
            end
        end else if (src_valid[m_owner] && out_ready) begin
            bt     = src_beat[32*m_owner +: 32];
            m_en   = 1'b1;
            m_beat = bt;
            if (m_left == 0) begin
                n = int'(bt[15:0]);
                m_left   = (n == 0) ? 1 : n;
                m_portal = src_portal[32*m_owner +: 32];
            end
            m_left--;
            if (m_left == 0) begin
                m_count = m_count + 32'd1;
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            m_en = 1'b0;
        end
    endtask

    // One clock: drive inputs after the falling edge, check, then check registers at the next falling edge.
    task automatic cycle();
        for (int i = 0; i < N; i++) begin
            src_valid[i]            = (src_q[i].size() > 0) && !gap[i];
            src_beat[32*i +: 32]    = (src_q[i].size() > 0) ? src_q[i][0] : 32'h0;
            src_portal[32*i +: 32]  = portal_in[i];
        end
        #1;
        check("src_ready", {28'h0, src_ready},
              (!RST && m_owner >= 0) ? {28'h0, (N'(out_ready) << m_owner)} : 32'h0);
        for (int i = 0; i < N; i++) begin
            if (src_valid[i] && src_ready[i]) void'(src_q[i].pop_front());
        end
        model_update();
        last_or = out_ready;
        @(negedge CLK);
        cyc++;
        check("en_beat", {31'h0, en_beat}, {31'h0, m_en});
        if (m_en) check("beat", beat, m_beat);
        check("portal", portal, m_portal);
        check("msg_count", msg_count, m_count);
        check("busy", {31'h0, busy}, (m_owner >= 0) ? 32'h1 : 32'h0);
        if (en_beat === 1'b1) log_q.push_back('{beat, portal, cyc, last_or});
    endtask

    // Header low 16 bits = length; data beats carry tag and index for ordering checks.
    task automatic push_msg(input int s, input int len, input int tag);
        int n;
        n = (len == 0) ? 1 : len;
        src_q[s].push_back({8'(tag), 8'h00, 16'(len)});
        for (int j = 1; j < n; j++)
            src_q[s].push_back({8'(tag), 8'(j), 16'($urandom_range(0, 5))});
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_queues();
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            done = (m_owner < 0) && !m_en;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) done = 1'b0;
            if (done) break;
            cycle();
        end
        check(name, {31'h0, done}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mc0;
        int bad;
        model_reset();
        RST = 1'b1; out_ready = 1'b1; gap = '0; src_valid = '0; src_beat = '0; src_portal = '0;
        for (int i = 0; i < N; i++) portal_in[i] = 32'(100 + i);
        @(negedge CLK);
        do_reset();
        check("rst_en_beat", {31'h0, en_beat}, 32'h0);
        check("rst_msg_count", msg_count, 32'h0);
        check("rst_portal", portal, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);

        // Single 3-beat message from source 2 on portal 5.
        log_q.delete();
        portal_in[2] = 32'd5;
        push_msg(2, 3, 2);
        drain("drain_single");
        check("single_pulses", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("single_header", log_q[0].b, 32'h0200_0003);
            check("single_portal", log_q[0].p, 32'd5);
            check("single_back2back", log_q[2].cyc - log_q[0].cyc, 2);
        end
        check("single_count", msg_count, 32'd1);
        check("single_busy", {31'h0, busy}, 32'h0);

        // Round-robin among sources 0, 1, 3 with 1-beat messages.
        do_reset();
        log_q.delete();
        for (int r = 0; r < 2; r++) begin
            push_msg(0, 1, 0); push_msg(1, 1, 1); push_msg(3, 1, 3);
        end
        drain("drain_rr");
        check("rr_pulses", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("rr_0", {24'h0, log_q[0].b[31:24]}, 32'd0);
            check("rr_1", {24'h0, log_q[1].b[31:24]}, 32'd1);
            check("rr_2", {24'h0, log_q[2].b[31:24]}, 32'd3);
            check("rr_3", {24'h0, log_q[3].b[31:24]}, 32'd0);
            check("rr_4", {24'h0, log_q[4].b[31:24]}, 32'd1);
            check("rr_5", {24'h0, log_q[5].b[31:24]}, 32'd3);
        end

        // No interleave: source 1 waits for all of source 0's 4 beats.
        do_reset();
        log_q.delete();
        push_msg(0, 4, 0);
        push_msg(1, 1, 1);
        drain("drain_nointlv");
        check("nointlv_pulses", log_q.size(), 5);
        if (log_q.size() == 5) begin
            bad = 0;
            for (int k = 0; k < 4; k++) if (log_q[k].b[31:24] != 8'd0) bad++;
            check("nointlv_src0_first", bad, 0);
            check("nointlv_src1_last", {24'h0, log_q[4].b[31:24]}, 32'd1);
        end

        // Backpressure: out_ready toggles during a 3-beat message.
        do_reset();
        log_q.delete();
        push_msg(1, 3, 1);
        for (int c = 0; c < 40 && (src_q[1].size() > 0 || m_owner >= 0); c++) begin
            out_ready = (c % 2 == 0);
            cycle();
        end
        out_ready = 1'b1;
        drain("drain_bp");
        check("bp_pulses", log_q.size(), 3);
        bad = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            if (!log_q[k].acc_or) bad++;
            if (k > 0 && log_q[k].b[23:16] != 8'(k)) bad++;
        end
        check("bp_order_and_stall", bad, 0);

        // Zero-length header counts as a single-beat message.
        log_q.delete();
        mc0 = msg_count;
        src_q[1].push_back(32'h0000_0000);
        drain("drain_zero");
        check("zero_pulses", log_q.size(), 1);
        check("zero_count", msg_count, mc0 + 32'd1);

        // Reset after 2 of 5 beats abandons the message.
        do_reset();
        log_q.delete();
        push_msg(0, 5, 0);
        for (int c = 0; c < 50 && log_q.size() < 2; c++) cycle();
        check("midrst_two_beats", log_q.size(), 2);
        RST = 1'b1;
        clear_queues();
        cycle();
        RST = 1'b0;
        check("midrst_en_beat", {31'h0, en_beat}, 32'h0);
        check("midrst_count", msg_count, 32'h0);
        check("midrst_portal", portal, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        log_q.delete();
        portal_in[3] = 32'd77;
        push_msg(3, 2, 3);
        drain("drain_after_rst");
        check("after_rst_pulses", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("after_rst_header", log_q[0].b, 32'h0300_0002);
            check("after_rst_portal", log_q[0].p, 32'd77);
        end
        check("after_rst_count", msg_count, 32'd1);

        // Randomized traffic, gaps, backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 299) == 0);
            if (RST) clear_queues();
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_msg(i, $urandom_range(0, 5), i);
                gap[i] = ($urandom_range(0, 3) == 0);
                portal_in[i] = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        RST = 1'b0; gap = '0; out_ready = 1'b1;
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
